// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period sequencer and its island FSM.
// period_t is the encoder mode code seen on o_period.
package hdmi_pkg;

    typedef enum logic [2:0] {
        CTRL        = 3'd0,
        VID_PRE     = 3'd1,
        VID_GB      = 3'd2,
        VIDEO       = 3'd3,
        DI_PRE      = 3'd4,
        DI_GB_LEAD  = 3'd5,
        DI_DATA     = 3'd6,
        DI_GB_TRAIL = 3'd7
    } period_t;

    typedef enum logic [2:0] {
        IS_IDLE     = 3'd0,
        IS_PRE      = 3'd1,
        IS_GB_LEAD  = 3'd2,
        IS_DATA     = 3'd3,
        IS_GB_TRAIL = 3'd4
    } island_state_t;

    localparam int         PREAMBLE_LEN = 8;
    localparam int         GUARD_LEN    = 2;
    localparam int         MIN_CTRL     = 12;
    localparam logic [3:0] CTL_VID_PRE  = 4'b0001;
    localparam logic [3:0] CTL_DI_PRE   = 4'b0101;

endpackage

// File: rtl/hdmi_island_fsm.sv
// Data-island scheduler: grants one island slot per line and walks
// preamble / leading guard / payload / trailing guard, aligned to the output register.
module hdmi_island_fsm
    import hdmi_pkg::*;
#(
    parameter int DI_START = 656,
    parameter int DI_LEN   = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [11:0]   i_hcount,
    input  logic          i_di_req,
    input  logic          i_force_idle,
    output island_state_t o_state,
    output logic [4:0]    o_idx,
    output logic          o_grant
);

    localparam logic [11:0] START_H = 12'(DI_START);
    localparam logic [11:0] GRANT_H = 12'(DI_START - 1);
    localparam logic [5:0]  PRE_TC  = 6'(PREAMBLE_LEN - 1);
    localparam logic [5:0]  GB_TC   = 6'(GUARD_LEN - 1);
    localparam logic [5:0]  DATA_TC = 6'(DI_LEN - 1);

    island_state_t state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic          flag_q, flag_d;
    logic          grant_q, grant_d;

    // state_d/cnt_d describe the pixel currently on i_hcount, so the top can
    // register them alongside the video decode with no extra latency.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 6'd1;
        flag_d  = flag_q;
        grant_d = 1'b0;
        unique case (state_q)
            IS_IDLE: begin
                cnt_d = '0;
                if (i_hcount == START_H && flag_q) state_d = IS_PRE;
            end
            IS_PRE: if (cnt_q == PRE_TC) begin
                state_d = IS_GB_LEAD;
                cnt_d   = '0;
            end
            IS_GB_LEAD: if (cnt_q == GB_TC) begin
                state_d = IS_DATA;
                cnt_d   = '0;
            end
            IS_DATA: if (cnt_q == DATA_TC) begin
                state_d = IS_GB_TRAIL;
                cnt_d   = '0;
            end
            IS_GB_TRAIL: if (cnt_q == GB_TC) begin
                state_d = IS_IDLE;
                cnt_d   = '0;
                flag_d  = 1'b0;
            end
            default: begin
                state_d = IS_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Video periods win; an aborted island also gives up its slot.
        if (i_force_idle) begin
            if (state_q != IS_IDLE) flag_d = 1'b0;
            state_d = IS_IDLE;
            cnt_d   = '0;
        end
        if (i_hcount == GRANT_H && i_di_req && !flag_q) begin
            grant_d = 1'b1;
            flag_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IS_IDLE;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            grant_q <= grant_d;
        end
    end

    assign o_state = state_d;
    assign o_idx   = cnt_d[4:0];
    assign o_grant = grant_q;

endmodule

// File: rtl/hdmi_period_sequencer.sv
// Per-pixel HDMI period scheduler: video preamble/guard/active decode plus
// data-island insertion, all outputs registered one pixel after hcount/vcount.
module hdmi_period_sequencer
    import hdmi_pkg::*;
#(
    parameter int HA       = 640,
    parameter int HTOTAL   = 800,
    parameter int VA       = 480,
    parameter int VTOTAL   = 525,
    parameter int DI_START = 656,
    parameter int DI_LEN   = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [11:0] i_hcount,
    input  logic [11:0] i_vcount,
    input  logic        i_di_req,
    output logic        o_di_grant,
    output logic [2:0]  o_period,
    output logic [3:0]  o_ctl,
    output logic        o_data_en,
    output logic [4:0]  o_di_idx
);

    localparam logic [11:0] HA_W      = 12'(HA);
    localparam logic [11:0] VA_W      = 12'(VA);
    localparam logic [11:0] VTOTAL_W  = 12'(VTOTAL);
    localparam logic [11:0] PRE_LO    = 12'(HTOTAL - PREAMBLE_LEN - GUARD_LEN);
    localparam logic [11:0] PRE_HI    = 12'(HTOTAL - GUARD_LEN - 1);
    localparam logic [11:0] GB_LO     = 12'(HTOTAL - GUARD_LEN);
    localparam logic [11:0] GB_HI     = 12'(HTOTAL - 1);

    // The island plus its guard bands and a minimum control gap must fit
    // between the end of active video and the next video preamble.
    generate
        if (DI_START < HA ||
            DI_START + PREAMBLE_LEN + GUARD_LEN + DI_LEN + GUARD_LEN + MIN_CTRL
                > HTOTAL - PREAMBLE_LEN - GUARD_LEN ||
            DI_LEN > 32) begin : g_bad_window
            $error("hdmi_period_sequencer: data-island window does not fit in blanking");
        end
    endgenerate

    logic [11:0]   vcount_inc;
    logic [11:0]   vcount_next;
    logic          next_line_active;
    logic          in_video, in_vid_gb, in_vid_pre;
    island_state_t island_state;
    logic [4:0]    island_idx;

    assign vcount_inc       = i_vcount + 12'd1;
    assign vcount_next      = (vcount_inc == VTOTAL_W) ? 12'd0 : vcount_inc;
    assign next_line_active = vcount_next < VA_W;
    assign in_video   = (i_hcount < HA_W) && (i_vcount < VA_W);
    assign in_vid_gb  = (i_hcount >= GB_LO) && (i_hcount <= GB_HI) && next_line_active;
    assign in_vid_pre = (i_hcount >= PRE_LO) && (i_hcount <= PRE_HI) && next_line_active;

    hdmi_island_fsm #(
        .DI_START (DI_START),
        .DI_LEN   (DI_LEN)
    ) u_island (
        .clk          (clk),
        .rstn         (rstn),
        .i_hcount     (i_hcount),
        .i_di_req     (i_di_req),
        .i_force_idle (in_video || in_vid_gb || in_vid_pre),
        .o_state      (island_state),
        .o_idx        (island_idx),
        .o_grant      (o_di_grant)
    );

    period_t    period_q, period_d;
    logic [3:0] ctl_q, ctl_d;
    logic       data_en_q, data_en_d;
    logic [4:0] di_idx_q, di_idx_d;

    always_comb begin
        period_d  = CTRL;
        ctl_d     = 4'b0000;
        data_en_d = 1'b0;
        di_idx_d  = '0;
        if (in_video) begin
            period_d  = VIDEO;
            data_en_d = 1'b1;
        end else if (in_vid_gb) begin
            period_d = VID_GB;
        end else if (in_vid_pre) begin
            period_d = VID_PRE;
            ctl_d    = CTL_VID_PRE;
        end else begin
            unique case (island_state)
                IS_PRE: begin
                    period_d = DI_PRE;
                    ctl_d    = CTL_DI_PRE;
                end
                IS_GB_LEAD:  period_d = DI_GB_LEAD;
                IS_DATA: begin
                    period_d = DI_DATA;
                    di_idx_d = island_idx;
                end
                IS_GB_TRAIL: period_d = DI_GB_TRAIL;
                default:     period_d = CTRL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            period_q  <= CTRL;
            ctl_q     <= 4'b0000;
            data_en_q <= 1'b0;
            di_idx_q  <= '0;
        end else begin
            period_q  <= period_d;
            ctl_q     <= ctl_d;
            data_en_q <= data_en_d;
            di_idx_q  <= di_idx_d;
        end
    end

    assign o_period  = period_q;
    assign o_ctl     = ctl_q;
    assign o_data_en = data_en_q;
    assign o_di_idx  = di_idx_q;

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Directed bench for hdmi_period_sequencer: table of single-pixel decode vectors
// plus hand-written line sequences for island grant, lateness and reset.
module tb_hdmi_period_sequencer;
    import hdmi_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] i_hcount = '0;
    logic [11:0] i_vcount = '0;
    logic        i_di_req = 1'b0;
    logic        o_di_grant;
    logic [2:0]  o_period;
    logic [3:0]  o_ctl;
    logic        o_data_en;
    logic [4:0]  o_di_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hdmi_period_sequencer dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_hcount   (i_hcount),
        .i_vcount   (i_vcount),
        .i_di_req   (i_di_req),
        .o_di_grant (o_di_grant),
        .o_period   (o_period),
        .o_ctl      (o_ctl),
        .o_data_en  (o_data_en),
        .o_di_idx   (o_di_idx)
    );

    typedef struct {
        int         h;
        int         v;
        period_t    period;
        logic [3:0] ctl;
        logic       den;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one pixel, then sample its registered outputs 1 time unit after the edge.
    task automatic apply(input int h, input int v, input logic req);
        @(negedge clk);
        i_hcount = 12'(h);
        i_vcount = 12'(v);
        i_di_req = req;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input period_t p, input logic [3:0] ctl,
                             input logic den, input logic [4:0] idx, input logic grant);
        check({tag, " period"}, 32'(o_period), 32'(p));
        check({tag, " ctl"},    32'(o_ctl),    32'(ctl));
        check({tag, " den"},    32'(o_data_en), 32'(den));
        check({tag, " idx"},    32'(o_di_idx), 32'(idx));
        check({tag, " grant"},  32'(o_di_grant), 32'(grant));
    endtask

    // Expected blanking-region outputs for hcount h when an island is scheduled.
    task automatic exp_island(input int h, input bit island, output period_t p,
                              output logic [3:0] ctl, output logic [4:0] idx);
        p = CTRL; ctl = 4'b0000; idx = 5'd0;
        if (island) begin
            if (h >= 656 && h <= 663)      begin p = DI_PRE; ctl = 4'b0101; end
            else if (h >= 664 && h <= 665) p = DI_GB_LEAD;
            else if (h >= 666 && h <= 697) begin p = DI_DATA; idx = 5'(h - 666); end
            else if (h >= 698 && h <= 699) p = DI_GB_TRAIL;
        end
    endtask

    // Stream hcount h0..h1 on line v; req goes high at req_from and stays.
    task automatic run_line(input int v, input int h0, input int h1, input int req_from,
                            input bit island, output int grants);
        period_t    p;
        logic [3:0] ctl;
        logic [4:0] idx;
        grants = 0;
        for (int h = h0; h <= h1; h++) begin
            apply(h, v, logic'(h >= req_from));
            if (o_di_grant) grants++;
            exp_island(h, island, p, ctl, idx);
            check_all($sformatf("v=%0d h=%0d", v, h), p, ctl, 1'b0, idx,
                      logic'(island && h == 655));
        end
    endtask

    vec_t vecs[16];
    int   grants;

    initial begin
        vecs[0]  = '{790, 100, VID_PRE, 4'b0001, 1'b0};
        vecs[1]  = '{797, 100, VID_PRE, 4'b0001, 1'b0};
        vecs[2]  = '{798, 100, VID_GB,  4'b0000, 1'b0};
        vecs[3]  = '{799, 100, VID_GB,  4'b0000, 1'b0};
        vecs[4]  = '{0,   100, VIDEO,   4'b0000, 1'b1};
        vecs[5]  = '{639, 100, VIDEO,   4'b0000, 1'b1};
        vecs[6]  = '{640, 100, CTRL,    4'b0000, 1'b0};
        vecs[7]  = '{789, 100, CTRL,    4'b0000, 1'b0};
        vecs[8]  = '{790, 524, VID_PRE, 4'b0001, 1'b0};
        vecs[9]  = '{799, 524, VID_GB,  4'b0000, 1'b0};
        vecs[10] = '{790, 479, CTRL,    4'b0000, 1'b0};
        vecs[11] = '{798, 479, CTRL,    4'b0000, 1'b0};
        vecs[12] = '{0,   480, CTRL,    4'b0000, 1'b0};
        vecs[13] = '{639, 479, VIDEO,   4'b0000, 1'b1};
        vecs[14] = '{790, 478, VID_PRE, 4'b0001, 1'b0};
        vecs[15] = '{656, 100, CTRL,    4'b0000, 1'b0};

        // Reset state, then async reset mid-line during active video.
        #1;
        check_all("reset", CTRL, 4'b0000, 1'b0, 5'd0, 1'b0);
        #3 rstn = 1'b1;
        apply(300, 10, 1'b0);
        check_all("pre-rst h=300", VIDEO, 4'b0000, 1'b1, 5'd0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        check_all("async rst", CTRL, 4'b0000, 1'b0, 5'd0, 1'b0);
        rstn = 1'b1;
        apply(301, 10, 1'b0);
        check_all("post-rst h=301", VIDEO, 4'b0000, 1'b1, 5'd0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i].h, vecs[i].v, 1'b0);
            check_all($sformatf("vec%0d h=%0d v=%0d", i, vecs[i].h, vecs[i].v),
                      vecs[i].period, vecs[i].ctl, vecs[i].den, 5'd0, 1'b0);
        end

        // Granted island on an active line and on a vertical-blanking line.
        run_line(100, 650, 702, 0, 1'b1, grants);
        check("grants v=100", 32'(grants), 32'd1);
        run_line(500, 650, 702, 0, 1'b1, grants);
        check("grants v=500", 32'(grants), 32'd1);

        // Late request waits a line; held request yields one grant per line.
        run_line(200, 640, 720, 660, 1'b0, grants);
        check("grants late v=200", 32'(grants), 32'd0);
        for (int v = 201; v <= 203; v++) begin
            run_line(v, 640, 720, 0, 1'b1, grants);
            check($sformatf("grants held v=%0d", v), 32'(grants), 32'd1);
        end

        // Reset during the payload kills the island for the rest of the line.
        run_line(300, 650, 680, 0, 1'b1, grants);
        #2 rstn = 1'b0;
        #1;
        check_all("rst in island", CTRL, 4'b0000, 1'b0, 5'd0, 1'b0);
        rstn = 1'b1;
        run_line(300, 681, 720, 0, 1'b0, grants);
        check("grants after rst", 32'(grants), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_period_sequencer.md
Name: hdmi_period_sequencer

Overview:
- Per-pixel scheduler for the HDMI TMDS channel encoders. It decides which HDMI period each pixel clock belongs to: control, video preamble, video guard band, active video, or data island with its preamble and guard bands.
- Drives the encoder mode select and the CTL[3:0] preamble codes.
- Arbitrates one data-island slot per line for an auxiliary packet requester using a req/grant handshake.
- Sits between pixel_counter/hdmi_controller and the three tmds_encoder instances.

Parameters:
- HA, 640, active pixels per line
- HTOTAL, 800, total pixels per line
- VA, 480, active lines per frame
- VTOTAL, 525, total lines per frame
- DI_START, 656, hcount at which a granted data-island preamble begins; must lie in horizontal blanking
- DI_LEN, 32, data-island payload length in pixels

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- i_hcount  in  12  current horizontal position from pixel_counter
- i_vcount  in  12  current vertical position from pixel_counter
- i_di_req  in  1  auxiliary packet requester wants an island; held until granted
- o_di_grant  out  1  one-cycle pulse; the island is scheduled for this line
- o_period  out  3  period_t code for this pixel
- o_ctl  out  4  CTL3..CTL0 for the encoders (CTL1:0 to green, CTL3:2 to red)
- o_data_en  out  1  high only during active video pixels
- o_di_idx  out  5  payload pixel index 0..DI_LEN-1 during DI_DATA, else 0

Behaviour:
- Latency: all outputs registered, valid one clk after the corresponding hcount/vcount.
- Reset (rstn low, async): o_period=CTRL, o_ctl=0, o_data_en=0, o_di_grant=0, o_di_idx=0, island-granted flag cleared.
- Define next_line_active = ((i_vcount+1 == VTOTAL) ? 0 : i_vcount+1) < VA.
- Decode priority, highest first:
  - VIDEO: i_hcount<HA and i_vcount<VA. o_data_en=1, o_ctl=0.
  - VID_GB: i_hcount in [HTOTAL-2, HTOTAL-1] and next_line_active.
  - VID_PRE: i_hcount in [HTOTAL-10, HTOTAL-3] and next_line_active. o_ctl=4'b0001.
  - Island states, only when the island-granted flag is set:
    - DI_PRE: 8 cycles from DI_START, o_ctl=4'b0101.
    - DI_GB_LEAD: 2 cycles.
    - DI_DATA: DI_LEN cycles, o_di_idx counts 0..DI_LEN-1.
    - DI_GB_TRAIL: 2 cycles.
  - CTRL: everything else. o_ctl=0.
- o_ctl is 0 in every period other than VID_PRE and DI_PRE.
- Island FSM states: IDLE, PRE, GB_LEAD, DATA, GB_TRAIL. Counter is 6 bits.
  - IDLE->PRE when i_hcount==DI_START and the flag is set.
  - Each state advances on counter terminal count.
  - GB_TRAIL->IDLE clears the flag.
- Arbitration:
  - o_di_grant pulses when i_hcount==DI_START-1, i_di_req=1 and the flag is clear; the same edge sets the flag.
  - At most one grant per line.
  - A request arriving after DI_START-1 waits for the next line.
  - Grants are allowed on vertical-blanking lines and on active lines.
- Window rule (elaboration-time check, $error on violation): DI_START>=HA and DI_START+12+DI_LEN+12 <= HTOTAL-10. The trailing 12 is the minimum control period before the video preamble.
- Overlap: video preamble/guard and island never overlap when the window rule holds. If they do overlap anyway, the video states win and the island FSM is forced to IDLE.
- Wrap-around: hcount HTOTAL-1 -> 0 and vcount VTOTAL-1 -> 0 are handled by next_line_active; the preamble before line 0 occurs on line VTOTAL-1.
- Reset mid-island: FSM returns to IDLE and the flag clears. The requester must re-request; no grant is lost silently because o_di_grant was already observed.

Decomposition:
- hdmi_pkg holds:
  - period_t enum: CTRL, VID_PRE, VID_GB, VIDEO, DI_PRE, DI_GB_LEAD, DI_DATA, DI_GB_TRAIL.
  - Constants PREAMBLE_LEN=8, GUARD_LEN=2, CTL_VID_PRE=4'b0001, CTL_DI_PRE=4'b0101, MIN_CTRL=12.
- Sub-module hdmi_island_fsm (island FSM, counter, grant flag); the top does video decode and output registering.

Test Plan:
- Reset asserted mid-line with hcount=300, vcount=10 -> all outputs 0/CTRL asynchronously; after release, o_period tracks position one clk later.
- Line vcount=100: hcount 790..797 -> VID_PRE with o_ctl=0001; 798..799 -> VID_GB; 0..639 -> VIDEO with o_data_en=1; 640 -> CTRL.
- vcount=VTOTAL-1=524, hcount 790..799 -> preamble+guard present. vcount=479, hcount 790 -> CTRL, no preamble (next line 480 inactive).
- i_di_req=1 held, hcount=655 -> o_di_grant pulse one clk later. Then 656..663 DI_PRE ctl=0101, 664..665 DI_GB_LEAD, 666..697 DI_DATA with idx 0..31, 698..699 DI_GB_TRAIL, 700 CTRL.
- i_di_req rises at hcount=660 -> no grant this line; grant at hcount=655 of the next line; exactly one grant per line with req held over 3 lines.
- Reset pulsed at hcount=680 during DI_DATA -> period CTRL and no island on the remainder of that line.
